cic_decim_ctrl: RTL and testbench
=================================

Name: cic_decim_ctrl

Overview:
Sequencer for the 1-bit-input CIC decimator.
- Owns the integrator clear/enable and the comb-stage strobe. The comb runs on a single-clock enable, not a derived clock.
- Discards the comb pipeline warm-up samples.
- Presents decimated samples on a valid/ready interface with a one-entry hold buffer and a sticky overrun flag.
- Sits between the CIC datapath and the downstream sample consumer.

Parameters:
STAGES, 4, number of integrator/comb stages; also the number of warm-up comb outputs discarded.
RATIO_W, 4, width of the decimation-ratio configuration.
DATA_W, 17, width of the comb output (1 + STAGES*RATIO_W).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en_i  input  1  run request; rising level starts a run, low stops it
ratio_i  input  RATIO_W  decimation ratio R, sampled only when leaving IDLE
comb_data_i  input  DATA_W  comb chain output from datapath, valid in cycles where comb_en_o=1
int_clr_o  output  1  synchronous clear to all integrator and comb registers
int_en_o  output  1  integrator update enable
comb_en_o  output  1  comb-stage update strobe, one cycle wide
out_data_o  output  DATA_W  decimated sample
out_valid_o  output  1  out_data_o holds an unconsumed sample
out_ready_i  input  1  consumer accepts the sample when valid and ready are both high
overrun_o  output  1  sticky: a sample was lost
busy_o  output  1  state is not IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; phase counter=0; warm-up counter=0.
  - All outputs 0, including out_data_o.
- States: IDLE, CLEAR, WARMUP, RUN.
- IDLE:
  - int_en_o=0, comb_en_o=0.
  - en_i=1 -> CLEAR, and ratio register <= max(ratio_i, 2). Values 0 and 1 are clamped to 2.
- CLEAR (exactly 1 cycle):
  - int_clr_o=1.
  - Phase counter and warm-up counter <= 0.
  - out_valid_o <= 0; overrun_o <= 0.
  - Next state: WARMUP.
- WARMUP and RUN:
  - int_en_o=1 every cycle.
  - Phase counter counts 0..R-1 and wraps to 0.
  - comb_en_o=1 exactly in cycles where phase==R-1, giving a period of exactly R cycles.
  - First comb_en_o occurs R cycles after leaving CLEAR.
- WARMUP:
  - Each comb_en_o increments the warm-up counter. No samples are captured.
  - After the STAGES-th strobe -> RUN.
  - With STAGES=0 go straight to RUN (compile-time).
- RUN, capture:
  - On a comb_en_o cycle, comb_data_i is registered into out_data_o at that edge.
  - out_valid_o=1 in the next cycle, giving latency 1 from strobe to valid.
- Handshake:
  - out_valid_o stays high and out_data_o stays stable until a cycle with out_ready_i=1. out_valid_o falls after that edge unless a capture occurs in the same cycle.
  - Capture with out_valid_o=1 and out_ready_i=0: overwrite out_data_o, out_valid_o stays 1, overrun_o <= 1 (sticky).
  - Capture with out_valid_o=1 and out_ready_i=1: the old sample is consumed and the new one loaded; no overrun.
- en_i=0 in CLEAR, WARMUP or RUN:
  - Next state IDLE; int_en_o and comb_en_o are 0 from the next cycle.
  - A pending out_valid_o sample is kept until consumed.
  - overrun_o holds its value until the next CLEAR.
- ratio_i changes outside IDLE are ignored.
- Reset mid-run: immediate return to IDLE and reset values, regardless of the handshake.
- Arithmetic:
  - Phase counter is RATIO_W bits wide.
  - Warm-up counter is clog2(STAGES+1) bits wide and saturates at STAGES.

Optional Feature:
CIC_CTRL_GAIN_NORM_EN
- Defined:
  - Adds input port shift_i, width clog2(DATA_W), latched with the ratio on leaving IDLE.
  - Captured sample = comb_data_i >> shift (logical shift, zero-fill). Shifts >= DATA_W give 0.
- Undefined: no shift_i port; samples pass through unshifted.

Decomposition:
- Package cic_ctrl_pkg:
  - State enum (IDLE, CLEAR, WARMUP, RUN).
  - Constant MIN_RATIO=2.
  - Function for the warm-up counter width.
- One sub-module, cic_phase_ctr:
  - Loadable modulo-R counter with enable, sync clear and a terminal-count pulse.
  - Instantiated once for comb_en_o generation.

Test Plan:
- Reset, then en_i=1 with ratio_i=6, out_ready_i=1 -> int_clr_o high for 1 cycle; comb_en_o pulses every 6 cycles; first out_valid_o at the 5th strobe + 1 cycle; no overrun.
- ratio_i=0 and ratio_i=1 -> comb_en_o period is 2 cycles in both cases.
- RUN with out_ready_i=0 over two strobes -> out_data_o equals the 2nd captured value, overrun_o=1 and stays 1 until the next CLEAR.
- out_ready_i=1 exactly in a strobe cycle while out_valid_o=1 -> old value consumed, new value presented next cycle, overrun_o=0.
- en_i dropped during WARMUP after 2 strobes -> IDLE next cycle; re-enable -> full CLEAR and 4 discarded strobes again.
- Assert rst mid-RUN while out_valid_o=1 -> all outputs 0 asynchronously; with CIC_CTRL_GAIN_NORM_EN, shift_i=3 and comb_data_i=0x00F0 -> out_data_o=0x001E.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// cic_ctrl_pkg: shared definitions for the CIC decimator sequencer.
//   state_t        : sequencer states (IDLE, CLEAR, WARMUP, RUN)
//   MIN_RATIO      : smallest decimation ratio the sequencer will run with
//   wu_cnt_width() : width of the warm-up strobe counter for a given stage count
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int unsigned MIN_RATIO = 32'd2;

  // clog2(stages+1), never narrower than one bit so a zero-stage build still elaborates
  function automatic int unsigned wu_cnt_width(input int unsigned stages);
    int unsigned w;
    if (stages == 32'd0) begin
      w = 32'd1;
    end else begin
      w = $clog2(stages + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/cic_phase_ctr.sv
// cic_phase_ctr: modulo-N phase counter that marks the last phase of each period.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear to phase 0 (wins over en)
//   en        : advance the phase by one
//   modulus   : period N (caller guarantees N >= 2); counts 0..N-1
//   tc        : high while en=1 and the phase is N-1
module cic_phase_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic         tc
);

  logic [W-1:0] count_r;
  logic         last_s;

  assign last_s = (count_r == (modulus - W'(1)));
  assign tc     = en & last_s;

  // Phase register: clear, wrap at the last phase, otherwise hold or advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      if (last_s) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + W'(1);
      end
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sequencer for the 1-bit-input CIC decimator.
// Drives the integrator clear/enable and the single-cycle comb strobe, throws
// away the comb warm-up outputs, and hands decimated samples to the consumer
// through a one-entry valid/ready hold register with a sticky overrun flag.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en_i          : run request (high runs, low returns to IDLE)
//   ratio_i       : decimation ratio, latched when leaving IDLE (0/1 run as 2)
//   comb_data_i   : comb chain output, meaningful when comb_en_o=1
//   int_clr_o     : clear for integrator and comb registers (one cycle)
//   int_en_o      : integrator update enable
//   comb_en_o     : comb update strobe, once every ratio cycles
//   out_data_o    : held decimated sample
//   out_valid_o   : out_data_o holds an unconsumed sample
//   out_ready_i   : consumer takes the sample when valid and ready are high
//   overrun_o     : sticky, a sample was overwritten before being taken
//   busy_o        : sequencer is not IDLE
// Optional build macro CIC_CTRL_GAIN_NORM_EN adds shift_i (latched with the
// ratio); captured samples are then comb_data_i logically shifted right.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned STAGES  = 4,
  parameter int unsigned RATIO_W = 4,
  parameter int unsigned DATA_W  = 1 + STAGES * RATIO_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic [RATIO_W-1:0]        ratio_i,
`ifdef CIC_CTRL_GAIN_NORM_EN
  input  logic [$clog2(DATA_W)-1:0] shift_i,
`endif
  input  logic [DATA_W-1:0]         comb_data_i,
  output logic                      int_clr_o,
  output logic                      int_en_o,
  output logic                      comb_en_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      overrun_o,
  output logic                      busy_o
);

  localparam int unsigned        WU_W    = wu_cnt_width(STAGES);
  localparam logic [WU_W-1:0]    WU_MAX  = WU_W'(STAGES);
  localparam logic [WU_W-1:0]    WU_LAST = WU_W'(STAGES - 32'd1);
  localparam logic [RATIO_W-1:0] MIN_R   = RATIO_W'(MIN_RATIO);

  state_t              state_r;
  state_t              state_s;
  logic [RATIO_W-1:0]  ratio_r;
  logic [WU_W-1:0]     wu_cnt_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_valid_r;
  logic                overrun_r;
  logic [DATA_W-1:0]   cap_data_s;
  logic                start_s;
  logic                tc_s;
  logic                capture_s;
  logic                warmup_done_s;
  logic                skip_warmup_s;
  logic                int_clr_s;
  logic                int_en_s;
  logic                busy_s;

  // With no comb stages there is nothing to flush, so CLEAR goes straight to RUN
  generate
    if (STAGES == 0) begin : g_no_warmup
      assign skip_warmup_s = 1'b1;
    end else begin : g_warmup
      assign skip_warmup_s = 1'b0;
    end
  endgenerate

  assign start_s       = (state_r == IDLE) && en_i;
  assign capture_s     = tc_s && (state_r == RUN);
  assign warmup_done_s = (state_r == WARMUP) && tc_s && (wu_cnt_r == WU_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state selection and per-state control decode
  always_comb begin
    state_s   = state_r;
    int_clr_s = 1'b0;
    int_en_s  = 1'b0;
    busy_s    = 1'b1;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (en_i) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        int_clr_s = 1'b1;
        if (!en_i) begin
          state_s = IDLE;
        end else if (skip_warmup_s) begin
          state_s = RUN;
        end else begin
          state_s = WARMUP;
        end
      end
      WARMUP: begin
        int_en_s = 1'b1;
        if (!en_i) begin
          state_s = IDLE;
        end else if (warmup_done_s) begin
          state_s = RUN;
        end else begin
          state_s = WARMUP;
        end
      end
      RUN: begin
        int_en_s = 1'b1;
        if (!en_i) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // The phase counter advances with the integrators and is zeroed in CLEAR,
  // so the first strobe lands on the ratio-th integrating cycle
  cic_phase_ctr #(
    .W (RATIO_W)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .clr     (int_clr_s),
    .en      (int_en_s),
    .modulus (ratio_r),
    .tc      (tc_s)
  );

  // Ratio latch on leaving IDLE; ratios below two are run as two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio_r <= {RATIO_W{1'b0}};
    end else if (start_s) begin
      ratio_r <= (ratio_i < MIN_R) ? MIN_R : ratio_i;
    end
  end

`ifdef CIC_CTRL_GAIN_NORM_EN
  logic [$clog2(DATA_W)-1:0] shift_r;

  // Gain-normalising shift, latched together with the ratio
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {$clog2(DATA_W){1'b0}};
    end else if (start_s) begin
      shift_r <= shift_i;
    end
  end

  // Shift amounts at or beyond DATA_W shift everything out and yield zero
  assign cap_data_s = comb_data_i >> shift_r;
`else
  assign cap_data_s = comb_data_i;
`endif

  // Warm-up strobe counter: zeroed in CLEAR, counts WARMUP strobes, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wu_cnt_r <= {WU_W{1'b0}};
    end else if (state_r == CLEAR) begin
      wu_cnt_r <= {WU_W{1'b0}};
    end else if ((state_r == WARMUP) && tc_s && (wu_cnt_r != WU_MAX)) begin
      wu_cnt_r <= wu_cnt_r + WU_W'(1);
    end
  end

  // One-entry hold buffer: capture on RUN strobes, drop on handshake,
  // flag a capture that overwrites an unconsumed sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (state_r == CLEAR) begin
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (capture_s) begin
      out_data_r  <= cap_data_s;
      out_valid_r <= 1'b1;
      if (out_valid_r && !out_ready_i) begin
        overrun_r <= 1'b1;
      end
    end else if (out_valid_r && out_ready_i) begin
      out_valid_r <= 1'b0;
    end
  end

  assign int_clr_o   = int_clr_s;
  assign int_en_o    = int_en_s;
  assign comb_en_o   = tc_s;
  assign busy_o      = busy_s;
  assign out_data_o  = out_data_r;
  assign out_valid_o = out_valid_r;
  assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb_cic_decim_ctrl: self-checking bench for cic_decim_ctrl.
// A behavioural model (cycles-since-clear arithmetic) is compared against every
// output on every falling edge; directed tables and sequences cover the corner
// cases, followed by a randomized run. Inputs change on falling edges only.
module tb_cic_decim_ctrl;

  localparam int STAGES  = 4;
  localparam int RATIO_W = 4;
  localparam int DATA_W  = 1 + STAGES * RATIO_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en_i = 1'b0;
  logic [RATIO_W-1:0]  ratio_i = '0;
  logic [DATA_W-1:0]   comb_data_i = '0;
  logic                out_ready_i = 1'b1;
  logic                int_clr_o, int_en_o, comb_en_o, out_valid_o, overrun_o, busy_o;
  logic [DATA_W-1:0]   out_data_o;
`ifdef CIC_CTRL_GAIN_NORM_EN
  logic [$clog2(DATA_W)-1:0] shift_i = '0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int data_mode = 1;   // 0 random, 1 ramp by cycle, 2 constant 0x00F0

  // reference model state
  int                m_mode  = 0;   // 0 idle, 1 clear, 2 integrating
  int                m_t     = 0;   // cycles since leaving clear
  int                m_R     = 2;
  int                m_shift = 0;
  bit                m_valid = 1'b0;
  bit                m_ovr   = 1'b0;
  logic [DATA_W-1:0] m_data  = '0;

  always #5 clk = ~clk;

  cic_decim_ctrl #(
    .STAGES  (STAGES),
    .RATIO_W (RATIO_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .ratio_i     (ratio_i),
`ifdef CIC_CTRL_GAIN_NORM_EN
    .shift_i     (shift_i),
`endif
    .comb_data_i (comb_data_i),
    .int_clr_o   (int_clr_o),
    .int_en_o    (int_en_o),
    .comb_en_o   (comb_en_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t cyc=%0d: got %0h expected %0h", name, $time, cyc, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ramp(input int c);
    return DATA_W'(c * 131 + 7);
  endfunction

  function automatic bit m_strobe();
    return (m_mode == 2) && ((m_t % m_R) == (m_R - 1));
  endfunction

  task automatic model_step();
    bit ce, cap;
    if (rst) begin
      m_mode = 0; m_t = 0; m_R = 2; m_shift = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    end else begin
      ce  = m_strobe();
      cap = ce && (((m_t + 1) / m_R) > STAGES);
      if (m_mode == 1) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end else if (cap) begin
        if (m_valid && !out_ready_i) m_ovr = 1'b1;
        m_data  = DATA_W'(comb_data_i >> m_shift);
        m_valid = 1'b1;
      end else if (m_valid && out_ready_i) begin
        m_valid = 1'b0;
      end
      case (m_mode)
        0: if (en_i) begin
             m_mode = 1;
             m_R = (int'(ratio_i) < 2) ? 2 : int'(ratio_i);
`ifdef CIC_CTRL_GAIN_NORM_EN
             m_shift = int'(shift_i);
`endif
           end
        1: if (en_i) begin m_mode = 2; m_t = 0; end else m_mode = 0;
        default: if (en_i) m_t = m_t + 1; else m_mode = 0;
      endcase
    end
  endtask

  // model advances on every active edge and on reset assertion
  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // every output compared to the model mid-cycle
  initial forever begin
    @(negedge clk);
    chk("int_clr",   32'(int_clr_o),   32'(m_mode == 1));
    chk("int_en",    32'(int_en_o),    32'(m_mode == 2));
    chk("comb_en",   32'(comb_en_o),   32'(m_strobe()));
    chk("busy",      32'(busy_o),      32'(m_mode != 0));
    chk("out_valid", 32'(out_valid_o), 32'(m_valid));
    chk("overrun",   32'(overrun_o),   32'(m_ovr));
    chk("out_data",  32'(out_data_o),  32'(m_data));
  end

  task automatic next();
    @(negedge clk);
    cyc++;
    case (data_mode)
      0:       comb_data_i = DATA_W'($urandom);
      1:       comb_data_i = ramp(cyc);
      default: comb_data_i = DATA_W'(17'h000F0);
    endcase
  endtask

  // go idle, then request a run; returns at the CLEAR cycle (cyc = 0)
  task automatic start_run(input logic [RATIO_W-1:0] r);
    en_i = 1'b0;
    next();
    next();
    ratio_i = r;
    en_i    = 1'b1;
    cyc     = -1;
    next();
  endtask

  typedef struct {
    logic [RATIO_W-1:0] ratio;
    int                 exp_r;
    int                 exp_fv;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int strobes;
    vecs[0] = '{4'd6,  6,  31};
    vecs[1] = '{4'd0,  2,  11};
    vecs[2] = '{4'd1,  2,  11};
    vecs[3] = '{4'd3,  3,  16};
    vecs[4] = '{4'd15, 15, 76};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy_o),      32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data",  32'(out_data_o),  32'd0);
    chk("rst_clr",   32'(int_clr_o),   32'd0);
    #2 rst = 1'b0;

    // ratio/timing table, consumer always ready
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int first_s, second_s, fv, guard;
      start_run(vecs[i].ratio);
      chk("clr_pulse", 32'(int_clr_o), 32'd1);
      ratio_i = 4'hF;
      first_s = -1; second_s = -1; fv = -1; guard = 0;
      while (fv < 0 && guard < 200) begin
        next();
        guard++;
        if (cyc == 1) chk("clr_width", 32'(int_clr_o), 32'd0);
        if (comb_en_o) begin
          if (first_s < 0) first_s = cyc;
          else if (second_s < 0) second_s = cyc;
        end
        if (out_valid_o) fv = cyc;
      end
      chk("first_strobe", 32'(first_s), 32'(vecs[i].exp_r));
      chk("period",       32'(second_s - first_s), 32'(vecs[i].exp_r));
      chk("first_valid",  32'(fv), 32'(vecs[i].exp_fv));
      chk("no_overrun",   32'(overrun_o), 32'd0);
    end

    // overrun: two captures with no consumer, flag sticky until next CLEAR
    out_ready_i = 1'b0;
    start_run(4'd2);
    while (cyc < 11) next();
    chk("ovr_first_data", 32'(out_data_o), 32'(ramp(10)));
    chk("ovr_first_flag", 32'(overrun_o), 32'd0);
    while (cyc < 13) next();
    chk("ovr_second_data", 32'(out_data_o), 32'(ramp(12)));
    chk("ovr_set",         32'(overrun_o), 32'd1);
    while (cyc < 20) next();
    en_i = 1'b0;
    next();
    chk("stop_busy",  32'(busy_o),      32'd0);
    chk("stop_inten", 32'(int_en_o),    32'd0);
    chk("stop_valid", 32'(out_valid_o), 32'd1);
    chk("stop_ovr",   32'(overrun_o),   32'd1);
    start_run(4'd2);
    chk("clear_ovr_hold", 32'(overrun_o), 32'd1);
    next();
    chk("clear_ovr",   32'(overrun_o),   32'd0);
    chk("clear_valid", 32'(out_valid_o), 32'd0);

    // consume exactly in the strobe cycle: no overrun
    out_ready_i = 1'b0;
    start_run(4'd3);
    while (cyc < 16) next();
    chk("hs_hold_data", 32'(out_data_o), 32'(ramp(15)));
    while (cyc < 18) next();
    out_ready_i = 1'b1;
    next();
    out_ready_i = 1'b0;
    chk("hs_new_data",  32'(out_data_o),  32'(ramp(18)));
    chk("hs_new_valid", 32'(out_valid_o), 32'd1);
    chk("hs_no_ovr",    32'(overrun_o),   32'd0);
    out_ready_i = 1'b1;
    next();
    chk("hs_consumed", 32'(out_valid_o), 32'd0);

    // drop run request in WARMUP after two strobes, then full restart
    start_run(4'd4);
    while (cyc < 9) next();
    en_i = 1'b0;
    next();
    chk("wu_drop_busy",  32'(busy_o),    32'd0);
    chk("wu_drop_inten", 32'(int_en_o),  32'd0);
    chk("wu_drop_comb",  32'(comb_en_o), 32'd0);
    start_run(4'd4);
    chk("wu_reclear", 32'(int_clr_o), 32'd1);
    strobes = 0;
    while (cyc < 20) begin
      next();
      if (comb_en_o && !out_valid_o) strobes++;
    end
    chk("wu_no_early_valid", 32'(out_valid_o), 32'd0);
    next();
    chk("wu_strobes",     32'(strobes),     32'd5);
    chk("wu_first_valid", 32'(out_valid_o), 32'd1);

    // asynchronous reset mid-RUN with a pending sample
    out_ready_i = 1'b0;
`ifdef CIC_CTRL_GAIN_NORM_EN
    data_mode = 2;
    shift_i   = 3;
`endif
    start_run(4'd2);
    while (cyc < 11) next();
    chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
`ifdef CIC_CTRL_GAIN_NORM_EN
    chk("gain_shift", 32'(out_data_o), 32'h0000001E);
`else
    chk("pre_rst_data", 32'(out_data_o), 32'(ramp(10)));
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_data",  32'(out_data_o),  32'd0);
    chk("arst_busy",  32'(busy_o),      32'd0);
    chk("arst_inten", 32'(int_en_o),    32'd0);
    chk("arst_comb",  32'(comb_en_o),   32'd0);
    chk("arst_ovr",   32'(overrun_o),   32'd0);
    chk("arst_clr",   32'(int_clr_o),   32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // randomized run against the model
    data_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      next();
      out_ready_i = ($urandom_range(0, 2) != 0);
      ratio_i     = RATIO_W'($urandom_range(0, 6));
`ifdef CIC_CTRL_GAIN_NORM_EN
      shift_i     = 5'($urandom_range(0, 20));
`endif
      if (en_i) begin
        if ($urandom_range(0, 59) == 0) en_i = 1'b0;
      end else begin
        if ($urandom_range(0, 2) == 0) en_i = 1'b1;
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
